// File: rtl/reset_ctrl_pkg.sv
// Shared types and default timing constants for the reset controller.
package reset_ctrl_pkg;

  // Controller states; RUN is the only state in which resn is released.
  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_WAIT_REL = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  // 50 ms minimum reset pulse at 160 MHz.
  localparam int unsigned PULSE_CYCLES_DEF    = 8000000;
  // 1 ms of stable level before a debounced source may change.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 160000;

endpackage

// File: rtl/reset_debounce.sv
// One reset request source: polarity normalisation, 2-flop synchroniser,
// then either a stable-level debouncer or a straight bypass.
module reset_debounce
  import reset_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit          DEBOUNCE_EN     = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic res,
  input  logic src,
  output logic deb
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic norm;
  logic sync1;
  logic sync2;

  assign norm = ACTIVE_LOW ? ~src : src;

  // Two-flop synchroniser on the active-high request.
  always_ff @(posedge clk) begin
    if (res) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= norm;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_EN) begin : g_deb
      logic [CW-1:0] cnt;
      logic          level;

      assign deb = level;

      // Follow the synchronised level only once it has differed from the
      // current output for DEBOUNCE_CYCLES consecutive clocks.
      always_ff @(posedge clk) begin
        if (res) begin
          cnt   <= '0;
          level <= 1'b0;
        end else if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          cnt   <= '0;
          level <= sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end else begin : g_byp
      assign deb = sync2;
    end
  endgenerate

endmodule

// File: rtl/reset_ctrl.sv
// Reset controller: debounced request sources drive a minimum-length
// active-low reset pulse, with a sticky cause record and an event counter.
module reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int unsigned          NUM_SRC         = 2,
  parameter int unsigned          PULSE_CYCLES    = PULSE_CYCLES_DEF,
  parameter int unsigned          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [NUM_SRC-1:0]   DEBOUNCE_MASK   = '1,
  parameter logic [NUM_SRC-1:0]   SRC_ACTIVE_LOW  = '1
) (
  input  logic               clock_160,
  input  logic               res,
  input  logic [NUM_SRC-1:0] async_src,
  input  logic               cause_clr,
  output logic               resn,
  output logic [NUM_SRC-1:0] cause,
  output logic [7:0]         count,
  output logic [1:0]         state
);

  localparam int PW = $clog2(PULSE_CYCLES);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);

  logic [NUM_SRC-1:0] req;
  logic               any_req;
  state_t             st;
  logic [PW-1:0]      pulse_cnt;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      reset_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_EN     (DEBOUNCE_MASK[i]),
        .ACTIVE_LOW      (SRC_ACTIVE_LOW[i])
      ) u_deb (
        .clk (clock_160),
        .res (res),
        .src (async_src[i]),
        .deb (req[i])
      );
    end
  endgenerate

  assign any_req = |req;
  assign state   = st;

  // Reset sequencer: pulse counter, resn, cause and event count all
  // update together so resn is released only on entry to RUN.
  always_ff @(posedge clock_160) begin
    if (res) begin
      st        <= ST_ACTIVE;
      pulse_cnt <= PULSE_LOAD;
      resn      <= 1'b0;
      cause     <= '0;
      count     <= '0;
    end else begin
      case (st)
        ST_RUN: begin
          if (any_req) begin
            st        <= ST_ACTIVE;
            pulse_cnt <= PULSE_LOAD;
            resn      <= 1'b0;
            cause     <= cause | req;
            if (count != 8'hFF) count <= count + 8'd1;
          end else if (cause_clr) begin
            cause <= '0;
          end
        end
        ST_ACTIVE: begin
          cause <= cause | req;
          if (pulse_cnt == '0) begin
            if (any_req) begin
              st <= ST_WAIT_REL;
            end else begin
              st   <= ST_RUN;
              resn <= 1'b1;
            end
          end else begin
            pulse_cnt <= pulse_cnt - PW'(1);
          end
        end
        ST_WAIT_REL: begin
          cause <= cause | req;
          if (!any_req) begin
            st   <= ST_RUN;
            resn <= 1'b1;
          end
        end
        default: begin
          st        <= ST_ACTIVE;
          pulse_cnt <= PULSE_LOAD;
          resn      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reset_ctrl.md
RESET_CTRL -- requirements
Module: reset_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, giving the number of reset request sources (range 1..8).
REQ-002 SHALL have parameter PULSE_CYCLES, default 8000000, giving the minimum resn low time in clocks (50 ms at 160 MHz, range 2..2^24).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 160000, giving the stable-level time in clocks a source needs before its debounced value changes (range 1..2^20).
REQ-004 SHALL have parameter DEBOUNCE_MASK, default all ones, NUM_SRC bits; a bit set to 1 debounces that source, 0 bypasses debounce (prop-plug style input).
REQ-005 SHALL have parameter SRC_ACTIVE_LOW, default all ones, NUM_SRC bits; a bit set to 1 makes that source request reset when low.
REQ-006 SHALL have port clock_160  input  1  system clock; all logic on the rising edge.
REQ-007 SHALL have port res  input  1  reset; synchronous and active-high.
REQ-008 SHALL have port async_src  input  NUM_SRC  asynchronous reset requests (buttons, plug resn).
REQ-009 SHALL have port cause_clr  input  1  single-cycle clear of cause.
REQ-010 SHALL have port resn  output  1  registered active-low reset to the P1V core.
REQ-011 SHALL have port cause  output  NUM_SRC  sticky record of the sources that caused reset.
REQ-012 SHALL have port count  output  8  saturating count of reset events.

Function
REQ-013 SHALL normalise each source to active-high per SRC_ACTIVE_LOW, then pass it through a 2-flop synchroniser.
REQ-014 SHALL change a debounced source to the synchronised level only after that level has been constant for DEBOUNCE_CYCLES consecutive clocks; any glitch restarts the count.
REQ-015 SHALL make a bypassed source (mask bit 0) equal the synchronised level, giving 2 clocks of latency.
REQ-016 SHALL implement states ACTIVE, WAIT_REL and RUN.
REQ-017 In RUN, when any debounced request is asserted, SHALL go to ACTIVE on the next clock, load the pulse counter with PULSE_CYCLES-1, and drive resn=0 on that same edge.
REQ-018 In ACTIVE, SHALL decrement the counter each clock; at 0, SHALL go to WAIT_REL if any request is still asserted, otherwise to RUN.
REQ-019 In WAIT_REL, SHALL go to RUN on the first clock with no request asserted.
REQ-020 SHALL drive resn=1 only in RUN; resn low time is therefore at least PULSE_CYCLES clocks.
REQ-021 SHALL not restart the counter on new requests during ACTIVE or WAIT_REL.
REQ-022 SHALL OR asserted requests into cause on every clock in ACTIVE and WAIT_REL, and on the RUN->ACTIVE edge.
REQ-023 SHALL zero cause on cause_clr only in RUN; if cause_clr coincides with a RUN->ACTIVE transition, the new requests are written and the clear is ignored.
REQ-024 SHALL increment count on each RUN->ACTIVE transition, saturating at 255.

Reset
REQ-025 On res=1, SHALL set state ACTIVE, counter PULSE_CYCLES-1, resn=0, cause=0, count=0, synchronisers and debounced values to inactive, and debounce counters to 0.
REQ-026 SHALL abort an in-progress pulse or debounce when res=1 and restart from the REQ-025 values; the power-on pulse does not increment count.

Structure
REQ-027 SHALL place the state enum and the default values of PULSE_CYCLES and DEBOUNCE_CYCLES in package reset_ctrl_pkg.
REQ-028 SHALL implement per-source synchronise plus debounce as sub-module reset_debounce, instantiated NUM_SRC times in a generate loop.
REQ-029 SHALL size the counters with $clog2 of their parameters.

Verification (NUM_SRC=2, PULSE_CYCLES=16, DEBOUNCE_CYCLES=4, DEBOUNCE_MASK=2'b01, SRC_ACTIVE_LOW=2'b11)
REQ-030 Release res with sources idle high -> resn low for exactly 16 clocks, then 1; cause=0 and count=0.
REQ-031 Pull src0 low for 3 clocks -> no reset and count unchanged; hold src0 low for 20 clocks -> resn falls 2+4+1 clocks after the edge and stays low until src0 has been released and debounced; cause=01 and count=1.
REQ-032 Pulse src1 low for 1 clock -> resn low for exactly 16 clocks; cause=10.
REQ-033 Assert src0 during a src1-triggered pulse -> pulse length stays 16; cause=11 and count increments once.
REQ-034 Drive cause_clr together with a new src1 request -> cause=10, not 00.
REQ-035 Generate 300 src1 pulses -> count saturates at 255.
